// File: rtl/control_unit.sv
// Sequencing FSM for the accumulator core: fetch, decode and execute over the
// shared bus, with a bounded memory handshake that halts the core on timeout.
module control_unit #(
  parameter int OP   = 8,
  parameter int ADDR = 8
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                run,
  input  logic [OP+ADDR-1:0]  bus_in,
  input  logic                mem_ready,
  input  logic                acc_zero,
  output logic                pc_valid,
  output logic                mem_valid,
  output logic                ir_valid,
  output logic                acc_valid,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                mar_load,
  output logic                ir_load,
  output logic                acc_load,
  output logic                mem_write,
  output logic [1:0]          alu_op,
  output logic                halted,
  output logic                bus_err,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FADDR, S_FMEM, S_DECODE, S_EADDR, S_EMEM, S_JUMP, S_HALT
  } state_t;

  localparam logic [OP-1:0] OPC_NOP = OP'(0);
  localparam logic [OP-1:0] OPC_LDA = OP'(1);
  localparam logic [OP-1:0] OPC_STA = OP'(2);
  localparam logic [OP-1:0] OPC_ADD = OP'(3);
  localparam logic [OP-1:0] OPC_SUB = OP'(4);
  localparam logic [OP-1:0] OPC_JMP = OP'(5);
  localparam logic [OP-1:0] OPC_JZ  = OP'(6);
  localparam logic [OP-1:0] OPC_HLT = {OP{1'b1}};
  localparam logic [3:0]    WAIT_MAX = 4'd15;

  state_t          state, state_n;
  logic [OP-1:0]   opcode, bus_opc;
  logic [3:0]      wait_cnt;
  logic            bus_err_q, timeout, in_mem, opc_legal;
  logic            unused_addr;

  assign bus_opc     = bus_in[OP+ADDR-1:ADDR];
  assign unused_addr = ^bus_in[ADDR-1:0];
  assign in_mem      = (state == S_FMEM) || (state == S_EMEM);
  assign opc_legal   = bus_opc inside {OPC_NOP, OPC_LDA, OPC_STA, OPC_ADD,
                                       OPC_SUB, OPC_JMP, OPC_JZ, OPC_HLT};

  // State, latched opcode, handshake wait counter and sticky error.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= S_IDLE;
      opcode    <= '0;
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_DECODE) opcode <= bus_opc;
      if (timeout) bus_err_q <= 1'b1;
      if ((state_n == S_FMEM || state_n == S_EMEM) && state_n != state)
        wait_cnt <= '0;
      else if (in_mem && !mem_ready && wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_comb begin
    state_n = state;
    timeout = 1'b0;
    case (state)
      S_IDLE:   if (run) state_n = S_FADDR;
      S_FADDR:  state_n = S_FMEM;
      S_FMEM, S_EMEM: begin
        // A ready on the saturating cycle still completes cleanly.
        if (mem_ready)
          state_n = (state == S_FMEM) ? S_DECODE : S_FADDR;
        else if (wait_cnt == WAIT_MAX) begin
          state_n = S_HALT;
          timeout = 1'b1;
        end
      end
      S_DECODE: begin
        case (bus_opc)
          OPC_LDA, OPC_STA, OPC_ADD, OPC_SUB: state_n = S_EADDR;
          OPC_JMP: state_n = S_JUMP;
          OPC_JZ:  state_n = acc_zero ? S_JUMP : S_FADDR;
          OPC_HLT: state_n = S_HALT;
          default: state_n = S_FADDR;
        endcase
      end
      S_EADDR:  state_n = S_EMEM;
      S_JUMP:   state_n = S_FADDR;
      S_HALT:   state_n = S_HALT;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    pc_valid  = 1'b0;
    mem_valid = 1'b0;
    ir_valid  = 1'b0;
    acc_valid = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    mar_load  = 1'b0;
    ir_load   = 1'b0;
    acc_load  = 1'b0;
    mem_write = 1'b0;
    alu_op    = 2'b00;
    halted    = 1'b0;
    illegal   = 1'b0;
    bus_err   = bus_err_q;
    case (state)
      S_FADDR: begin
        pc_valid = 1'b1;
        mar_load = 1'b1;
      end
      S_FMEM: begin
        mem_valid = 1'b1;
        ir_load   = mem_ready;
      end
      S_DECODE: begin
        ir_valid = 1'b1;
        pc_inc   = 1'b1;
        illegal  = !opc_legal;
      end
      S_EADDR: begin
        ir_valid = 1'b1;
        mar_load = 1'b1;
      end
      S_EMEM: begin
        if (opcode == OPC_STA) begin
          acc_valid = 1'b1;
          mem_write = 1'b1;
        end else begin
          mem_valid = 1'b1;
          acc_load  = mem_ready;
          if (opcode == OPC_ADD)      alu_op = 2'b01;
          else if (opcode == OPC_SUB) alu_op = 2'b10;
        end
      end
      S_JUMP: begin
        ir_valid = 1'b1;
        pc_load  = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed and randomized checks of control_unit against per-instruction
// cycle traces built from the instruction-level behaviour.
module tb_control_unit;
  localparam int OP = 8, ADDR = 8;

  logic        clk = 1'b0, nrst = 1'b0, run = 1'b0, mem_ready = 1'b0, acc_zero = 1'b0;
  logic [15:0] bus_in = '0;
  logic        pc_valid, mem_valid, ir_valid, acc_valid, pc_inc, pc_load, mar_load;
  logic        ir_load, acc_load, mem_write, halted, bus_err, illegal;
  logic [1:0]  alu_op;
  logic [14:0] outs;
  int          total = 0, bad = 0;
  bit          mon_en = 0;

  localparam logic [14:0] PCV = 15'h4000, MEMV = 15'h2000, IRV = 15'h1000, ACCV = 15'h0800;
  localparam logic [14:0] PCI = 15'h0400, PCL = 15'h0200, MARL = 15'h0100, IRL = 15'h0080;
  localparam logic [14:0] ACCL = 15'h0040, MEMW = 15'h0020, ALU_ADD = 15'h0008, ALU_SUB = 15'h0010;
  localparam logic [14:0] HLTO = 15'h0004, BERR = 15'h0002, ILL = 15'h0001;
  localparam logic [14:0] FADDR = PCV | MARL, FDONE = MEMV | IRL, DEC = IRV | PCI;
  localparam logic [14:0] EADDR = IRV | MARL, JUMP = IRV | PCL;

  always #5 clk = ~clk;

  control_unit #(.OP(OP), .ADDR(ADDR)) dut (
    .clk(clk), .nrst(nrst), .run(run), .bus_in(bus_in), .mem_ready(mem_ready),
    .acc_zero(acc_zero), .pc_valid(pc_valid), .mem_valid(mem_valid), .ir_valid(ir_valid),
    .acc_valid(acc_valid), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .ir_load(ir_load), .acc_load(acc_load), .mem_write(mem_write), .alu_op(alu_op),
    .halted(halted), .bus_err(bus_err), .illegal(illegal)
  );

  assign outs = {pc_valid, mem_valid, ir_valid, acc_valid, pc_inc, pc_load, mar_load,
                 ir_load, acc_load, mem_write, alu_op, halted, bus_err, illegal};

  // Bus-drive exclusivity on every cycle once state is defined.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      total++;
      assert ($onehot0({pc_valid, mem_valid, ir_valid, acc_valid}))
      else begin
        bad++;
        $display("FAIL bus_excl got=%b want=onehot0", {pc_valid, mem_valid, ir_valid, acc_valid});
      end
    end
  end

  task automatic cyc(input logic rdy, input logic [15:0] b, input logic az);
    @(negedge clk);
    mem_ready = rdy; bus_in = b; acc_zero = az;
    #1;
  endtask

  // Leaves the DUT in its first post-reset IDLE cycle with run=1.
  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0; run = 1'b0; mem_ready = 1'b0; bus_in = '0; acc_zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1; run = 1'b1;
    #1;
  endtask

  function automatic logic [14:0] emem_exp(input logic [7:0] op, input logic rdy);
    case (op)
      8'h02:   return ACCV | MEMW;
      8'h03:   return MEMV | ALU_ADD | (rdy ? ACCL : 15'h0);
      8'h04:   return MEMV | ALU_SUB | (rdy ? ACCL : 15'h0);
      default: return MEMV | (rdy ? ACCL : 15'h0);
    endcase
  endfunction

  task automatic test_reset();
    nrst = 1'b0; run = 1'b1; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    mon_en = 1;
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_outs got=%h want=%h", outs, 15'h0); end
    nrst = 1'b1;
    total++;
    if (outs !== '0) begin bad++; $display("FAIL release_idle got=%h want=%h", outs, 15'h0); end
    cyc(1, 16'h0000, 0);
    total++;
    if (outs !== FADDR) begin bad++; $display("FAIL first_faddr got=%h want=%h", outs, FADDR); end
  endtask

  task automatic test_nop();
    logic [14:0] e [4] = '{FADDR, FDONE, DEC, FADDR};
    int n = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 16'h0000, 0);
      if (pc_inc) n++;
      total++;
      if (outs !== e[i]) begin bad++; $display("FAIL nop_c%0d got=%h want=%h", i, outs, e[i]); end
    end
    total++;
    if (n != 1) begin bad++; $display("FAIL nop_pc_inc got=%0d want=1", n); end
  endtask

  task automatic test_exec();
    logic [14:0] e [5];
    logic [7:0]  op;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      op = 8'(k);
      e = '{FADDR, FDONE, DEC, EADDR, emem_exp(op, 1'b1)};
      for (int i = 0; i < 5; i++) begin
        cyc(1, {op, 8'h42}, 0);
        total++;
        if (outs !== e[i]) begin bad++; $display("FAIL exec_op%0d_c%0d got=%h want=%h", k, i, outs, e[i]); end
      end
    end
    cyc(1, 16'h0000, 0);
    total++;
    if (outs !== FADDR) begin bad++; $display("FAIL exec_end got=%h want=%h", outs, FADDR); end
  endtask

  task automatic test_jump();
    logic [7:0] ops [3] = '{8'h05, 8'h06, 8'h06};
    logic       azs [3] = '{1'b0, 1'b1, 1'b0};
    bit         tk;
    int         nload;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tk = (ops[k] == 8'h05) || azs[k];
      nload = 0;
      for (int i = 0; i < (tk ? 4 : 3); i++) begin
        cyc(1, {ops[k], 8'h10}, azs[k]);
        if (pc_load) nload++;
        total++;
        if (outs !== (i == 0 ? FADDR : i == 1 ? FDONE : i == 2 ? DEC : JUMP)) begin
          bad++; $display("FAIL jump%0d_c%0d got=%h", k, i, outs);
        end
      end
      total++;
      if (nload != (tk ? 1 : 0)) begin bad++; $display("FAIL jump%0d_pc_load got=%0d want=%0d", k, nload, tk); end
    end
    cyc(1, 16'h0000, 0);
    total++;
    if (outs !== FADDR) begin bad++; $display("FAIL jump_end got=%h want=%h", outs, FADDR); end
  endtask

  task automatic test_timeout();
    int nmem = 0;
    do_reset();
    cyc(1, 16'h0000, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 16'h0000, 0);
      if (outs === MEMV) nmem++;
    end
    total++;
    if (nmem != 16) begin bad++; $display("FAIL tmo_wait got=%0d want=16", nmem); end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 16'h0000, 0);
      total++;
      if (outs !== (HLTO | BERR)) begin bad++; $display("FAIL tmo_halt%0d got=%h want=%h", i, outs, HLTO | BERR); end
    end
    do_reset();
    total++;
    if (outs !== '0) begin bad++; $display("FAIL tmo_clear got=%h want=%h", outs, 15'h0); end
    // Ready arriving on the saturating cycle must not error.
    cyc(1, 16'h0000, 0);
    repeat (15) cyc(0, 16'h0000, 0);
    cyc(1, 16'h0000, 0);
    total++;
    if (outs !== FDONE) begin bad++; $display("FAIL edge_done got=%h want=%h", outs, FDONE); end
    cyc(1, 16'h0000, 0);
    total++;
    if (outs !== DEC) begin bad++; $display("FAIL edge_dec got=%h want=%h", outs, DEC); end
  endtask

  task automatic test_illegal_halt();
    logic [14:0] e [10] = '{FADDR, FDONE, DEC | ILL, FADDR, FDONE, DEC, HLTO, HLTO, HLTO, HLTO};
    int nill = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1, (i < 3) ? 16'h7E00 : 16'hFF00, 0);
      if (illegal) nill++;
      total++;
      if (outs !== e[i]) begin bad++; $display("FAIL illhlt_c%0d got=%h want=%h", i, outs, e[i]); end
    end
    total++;
    if (nill != 1) begin bad++; $display("FAIL ill_count got=%0d want=1", nill); end
  endtask

  task automatic test_reset_mid();
    logic [14:0] e [5] = '{FADDR, FDONE, DEC, EADDR, ACCV | MEMW};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(i < 4, 16'h02AA, 0);
      total++;
      if (outs !== e[i]) begin bad++; $display("FAIL rmid_c%0d got=%h want=%h", i, outs, e[i]); end
    end
    nrst = 1'b0;
    cyc(1, 16'h02AA, 0);
    total++;
    if (outs !== '0) begin bad++; $display("FAIL rmid_reset got=%h want=%h", outs, 15'h0); end
    nrst = 1'b1;
  endtask

  task automatic test_random();
    logic [14:0] eq [$];
    bit          rq [$];
    logic [7:0]  op;
    logic [15:0] b;
    int          wf, we, r;
    bit          az, ill;
    do_reset();
    repeat (60) begin
      r  = $urandom_range(0, 7);
      op = (r == 7) ? 8'($urandom_range(7, 254)) : 8'(r);
      ill = (r == 7);
      wf = $urandom_range(0, 3);
      we = $urandom_range(0, 3);
      az = 1'($urandom_range(0, 1));
      b  = {op, 8'($urandom)};
      eq.delete(); rq.delete();
      eq.push_back(FADDR); rq.push_back(1'($urandom));
      repeat (wf) begin eq.push_back(MEMV); rq.push_back(0); end
      eq.push_back(FDONE); rq.push_back(1);
      eq.push_back(DEC | (ill ? ILL : 15'h0)); rq.push_back(1'($urandom));
      if (op >= 8'h01 && op <= 8'h04) begin
        eq.push_back(EADDR); rq.push_back(1'($urandom));
        repeat (we) begin eq.push_back(emem_exp(op, 1'b0)); rq.push_back(0); end
        eq.push_back(emem_exp(op, 1'b1)); rq.push_back(1);
      end else if (op == 8'h05 || (op == 8'h06 && az)) begin
        eq.push_back(JUMP); rq.push_back(1'($urandom));
      end
      foreach (eq[i]) begin
        cyc(rq[i], b, az);
        total++;
        if (outs !== eq[i]) begin
          bad++; $display("FAIL rand_op%h_c%0d got=%h want=%h", op, i, outs, eq[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_exec();
    test_jump();
    test_timeout();
    test_illegal_halt();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
